// File: rtl/mer_meter_if.sv
// Bus bundle for the MER meter: symbol-rate inputs from the receive chain
// and the measurement results going back out.
interface mer_meter_if #(
  parameter int DATA_W = 18
);
  logic                     sym_clk_en;
  logic                     en;
  logic                     mode_4pam;
  logic signed [DATA_W-1:0] dec_var;
  logic signed [DATA_W-1:0] ref_lvl;
  logic signed [DATA_W-1:0] err_avg;
  logic        [DATA_W-1:0] err_sq_avg;
  logic        [1:0]        slice;
  logic                     result_valid;
  logic                     busy;

  modport master (
    output sym_clk_en, en, mode_4pam, dec_var,
    input  ref_lvl, err_avg, err_sq_avg, slice, result_valid, busy
  );

  modport slave (
    input  sym_clk_en, en, mode_4pam, dec_var,
    output ref_lvl, err_avg, err_sq_avg, slice, result_valid, busy
  );
endinterface

// File: rtl/mer_meter.sv
// MER measurement engine for a 2-PAM / 4-PAM receiver.
// One training window estimates the reference level (mean |dec_var|); every
// following window slices against that level, forms the error and reports
// mean error and mean squared error with a one-cycle valid pulse.
module mer_meter #(
  parameter int DATA_W = 18,
  parameter int LOG2_N = 22
) (
  input logic       sys_clk,
  input logic       reset,
  mer_meter_if.slave bus
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int EXT_W = DATA_W + 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TRAIN   = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;

  localparam logic signed [DATA_W-1:0] SMAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0]  SMAX_X = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0]  SMIN_X = {3'b111, {(DATA_W-1){1'b0}}};

  logic [1:0]               state_reg;
  logic [LOG2_N-1:0]        cnt_reg;
  logic                     mode_reg;
  logic                     flush_reg;
  logic                     flush_meas_reg;
  logic signed [DATA_W-1:0] err_reg;
  logic [ACC_W-1:0]         mag_acc_reg;
  logic signed [ACC_W-1:0]  err_acc_reg;
  logic [ACC_W-1:0]         err_sq_acc_reg;
  logic signed [DATA_W-1:0] ref_lvl_reg;
  logic signed [DATA_W-1:0] err_avg_reg;
  logic [DATA_W-1:0]        err_sq_avg_reg;
  logic [1:0]               slice_reg;
  logic                     result_valid_reg;

  logic                     active;
  logic                     sym;
  logic                     win_end;
  logic                     mode_cur;
  logic [DATA_W-1:0]        mag;
  logic signed [EXT_W-1:0]  dv_x;
  logic signed [EXT_W-1:0]  ref_x;
  logic signed [EXT_W-1:0]  half_x;
  logic signed [EXT_W-1:0]  trip_x;
  logic signed [EXT_W-1:0]  lvl_x;
  logic signed [EXT_W-1:0]  diff_x;
  logic [1:0]               slice_next;
  logic signed [DATA_W-1:0] err_next;
  logic signed [2*DATA_W-1:0] sq_prod;
  logic [DATA_W-1:0]        sq_val;
  logic signed [ACC_W-1:0]  err_tot;
  logic [ACC_W-1:0]         sq_tot;

  assign active   = (state_reg != S_IDLE);
  assign sym      = bus.sym_clk_en && bus.en && active;
  assign win_end  = sym && (cnt_reg == '1);
  // The first symbol of a window must already slice with the mode being latched.
  assign mode_cur = (cnt_reg == '0) ? bus.mode_4pam : mode_reg;

  assign dv_x   = {{2{bus.dec_var[DATA_W-1]}}, bus.dec_var};
  assign ref_x  = {{2{ref_lvl_reg[DATA_W-1]}}, ref_lvl_reg};
  assign half_x = ref_x >>> 1;
  assign trip_x = ref_x + half_x;
  assign diff_x = dv_x - lvl_x;

  // Magnitude of the decision variable; the most negative code saturates.
  always_comb begin
    mag = bus.dec_var;
    if (bus.dec_var == SMIN)
      mag = SMAX;
    else if (bus.dec_var[DATA_W-1])
      mag = -bus.dec_var;
  end

  // Slicer and mapper against the reference level held from the previous window.
  always_comb begin
    slice_next = 2'b10;
    lvl_x      = ref_x;
    if (mode_cur) begin
      if (dv_x >= ref_x) begin
        slice_next = 2'b11;
        lvl_x      = trip_x;
      end else if (dv_x >= 0) begin
        slice_next = 2'b10;
        lvl_x      = half_x;
      end else if (dv_x >= -ref_x) begin
        slice_next = 2'b01;
        lvl_x      = -half_x;
      end else begin
        slice_next = 2'b00;
        lvl_x      = -trip_x;
      end
    end else if (dv_x >= 0) begin
      slice_next = 2'b10;
      lvl_x      = ref_x;
    end else begin
      slice_next = 2'b01;
      lvl_x      = -ref_x;
    end
  end

  // Saturate the slicing error back to DATA_W bits.
  always_comb begin
    err_next = diff_x[DATA_W-1:0];
    if (diff_x > SMAX_X)
      err_next = SMAX;
    else if (diff_x < SMIN_X)
      err_next = SMIN;
  end

  // Squared error scaled back to the 1sDATA_W-1 grid; never negative.
  assign sq_prod = err_reg * err_reg;
  assign sq_val  = sq_prod[2*DATA_W-2:DATA_W-1];

  // Running totals including the lagged error register (used on accumulate and flush).
  assign err_tot = err_acc_reg + {{LOG2_N{err_reg[DATA_W-1]}}, err_reg};
  assign sq_tot  = err_sq_acc_reg + {{LOG2_N{1'b0}}, sq_val};

  // FSM, symbol counter and window-start mode latch.
  always_ff @(posedge sys_clk) begin
    if (reset || !bus.en) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      flush_reg      <= 1'b0;
      flush_meas_reg <= 1'b0;
      if (reset)
        mode_reg <= 1'b0;
    end else begin
      flush_reg      <= win_end;
      flush_meas_reg <= win_end && (state_reg == S_MEASURE);
      case (state_reg)
        S_IDLE:    state_reg <= S_TRAIN;
        S_TRAIN:   if (win_end) state_reg <= S_MEASURE;
        S_MEASURE: state_reg <= S_MEASURE;
        default:   state_reg <= S_IDLE;
      endcase
      if (sym) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == '0)
          mode_reg <= bus.mode_4pam;
      end
    end
  end

  // Accumulators; error is added one symbol late, the window's last error at flush.
  always_ff @(posedge sys_clk) begin
    if (reset || !bus.en) begin
      err_reg        <= '0;
      mag_acc_reg    <= '0;
      err_acc_reg    <= '0;
      err_sq_acc_reg <= '0;
    end else begin
      if (sym)
        err_reg <= err_next;
      if (flush_reg) begin
        mag_acc_reg    <= sym ? {{LOG2_N{1'b0}}, mag} : '0;
        err_acc_reg    <= '0;
        err_sq_acc_reg <= '0;
      end else if (sym) begin
        mag_acc_reg <= mag_acc_reg + {{LOG2_N{1'b0}}, mag};
        if (cnt_reg != '0) begin
          err_acc_reg    <= err_tot;
          err_sq_acc_reg <= sq_tot;
        end
      end
    end
  end

  // Result registers: slice per symbol, averages and pulse on the flush cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ref_lvl_reg      <= '0;
      err_avg_reg      <= '0;
      err_sq_avg_reg   <= '0;
      slice_reg        <= 2'b00;
      result_valid_reg <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      if (sym)
        slice_reg <= slice_next;
      if (bus.en && flush_reg) begin
        ref_lvl_reg <= mag_acc_reg[ACC_W-1:LOG2_N];
        if (flush_meas_reg) begin
          err_avg_reg      <= err_tot[ACC_W-1:LOG2_N];
          err_sq_avg_reg   <= sq_tot[ACC_W-1:LOG2_N];
          result_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.ref_lvl      = ref_lvl_reg;
  assign bus.err_avg      = err_avg_reg;
  assign bus.err_sq_avg   = err_sq_avg_reg;
  assign bus.slice        = slice_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.busy         = active;

endmodule

// File: tb/tb_mer_meter.sv
// Directed bench for mer_meter with LOG2_N=4 (16-symbol windows).
module tb_mer_meter;

  localparam int DATA_W = 18;
  localparam int LOG2_N = 4;
  localparam int NSYM   = 16;

  logic sys_clk;
  logic reset;

  mer_meter_if #(.DATA_W(DATA_W)) bus ();

  mer_meter #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic             mode;
    logic [3:0][31:0] pat;
    logic [31:0]      ref_v;
    logic [31:0]      eavg;
    logic [31:0]      esq;
    logic [3:0][1:0]  sl;
  } vec_t;

  vec_t vecs [4];
  int   checks;
  int   errors;
  int   pulse_cnt;

  // Count cycles in which the valid pulse is high.
  always @(negedge sys_clk) begin
    if (bus.result_valid === 1'b1)
      pulse_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input int dv, output logic [1:0] sl);
    bus.dec_var    = dv[DATA_W-1:0];
    bus.sym_clk_en = 1'b1;
    tick();
    sl = bus.slice;
    bus.sym_clk_en = 1'b0;
    tick();
  endtask

  task automatic run_win(input logic [3:0][31:0] pat, input int nsym);
    logic [1:0] sl;
    for (int i = 0; i < nsym; i++)
      send(int'($signed(pat[i % 4])), sl);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.en         = 1'b0;
    bus.sym_clk_en = 1'b0;
    bus.mode_4pam  = 1'b0;
    bus.dec_var    = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_vec(input int idx, input logic mode,
                         input int p0, input int p1, input int p2, input int p3,
                         input int rv, input int ea, input int es,
                         input logic [1:0] s0, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [1:0] s3);
    vecs[idx].mode   = mode;
    vecs[idx].pat[0] = p0;
    vecs[idx].pat[1] = p1;
    vecs[idx].pat[2] = p2;
    vecs[idx].pat[3] = p3;
    vecs[idx].ref_v  = rv;
    vecs[idx].eavg   = ea;
    vecs[idx].esq    = es;
    vecs[idx].sl[0]  = s0;
    vecs[idx].sl[1]  = s1;
    vecs[idx].sl[2]  = s2;
    vecs[idx].sl[3]  = s3;
  endtask

  logic [3:0][31:0] pat_off;
  logic [3:0][31:0] pat_2p;
  logic [1:0]       sl;
  int               p0;

  initial begin
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;

    set_vec(0, 1'b1, -12288, -4096, 4096, 12288, 8192, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11);
    set_vec(1, 1'b1, -11264, -3072, 5120, 13312, 8192, 1024, 8, 2'b00, 2'b01, 2'b10, 2'b11);
    set_vec(2, 1'b0, 8192, -8192, 8192, -8192, 8192, 0, 0, 2'b10, 2'b01, 2'b10, 2'b01);
    set_vec(3, 1'b0, -131072, -131072, -131072, -131072, 131071, -1, 0, 2'b01, 2'b01, 2'b01, 2'b01);

    // Reset state
    do_reset();
    chk("rst_ref", int'($signed(bus.ref_lvl)), 0);
    chk("rst_err_avg", int'($signed(bus.err_avg)), 0);
    chk("rst_err_sq", int'(bus.err_sq_avg), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.result_valid), 0);

    // Table-driven two-window runs
    for (int v = 0; v < 4; v++) begin
      do_reset();
      bus.en        = 1'b1;
      bus.mode_4pam = vecs[v].mode;
      tick();
      chk("busy_train", int'(bus.busy), 1);
      p0 = pulse_cnt;
      run_win(vecs[v].pat, NSYM);
      tick();
      chk("win1_ref", int'($signed(bus.ref_lvl)), int'(vecs[v].ref_v));
      chk("win1_no_pulse", pulse_cnt - p0, 0);
      p0 = pulse_cnt;
      for (int i = 0; i < NSYM; i++) begin
        send(int'($signed(vecs[v].pat[i % 4])), sl);
        if (i < 4)
          chk("win2_slice", int'(sl), int'(vecs[v].sl[i]));
      end
      chk("win2_valid_hi", int'(bus.result_valid), 1);
      chk("win2_ref", int'($signed(bus.ref_lvl)), int'(vecs[v].ref_v));
      chk("win2_err_avg", int'($signed(bus.err_avg)), int'($signed(vecs[v].eavg)));
      chk("win2_err_sq", int'(bus.err_sq_avg), int'(vecs[v].esq));
      tick();
      chk("win2_valid_lo", int'(bus.result_valid), 0);
      chk("win2_one_pulse", pulse_cnt - p0, 1);
      $display("vec %0d mode=%0d ref=%0d err_avg=%0d err_sq=%0d", v, vecs[v].mode,
               $signed(bus.ref_lvl), $signed(bus.err_avg), bus.err_sq_avg);
    end

    pat_off = vecs[1].pat;
    pat_2p[0] = 4096;
    pat_2p[1] = -4096;
    pat_2p[2] = 4096;
    pat_2p[3] = -4096;

    // Reset mid-MEASURE with counter at 7
    do_reset();
    bus.en        = 1'b1;
    bus.mode_4pam = 1'b1;
    tick();
    run_win(pat_off, NSYM);
    run_win(pat_off, NSYM);
    run_win(pat_off, 7);
    p0 = pulse_cnt;
    reset = 1'b1;
    tick();
    chk("mid_rst_ref", int'($signed(bus.ref_lvl)), 0);
    chk("mid_rst_err_avg", int'($signed(bus.err_avg)), 0);
    chk("mid_rst_err_sq", int'(bus.err_sq_avg), 0);
    chk("mid_rst_slice", int'(bus.slice), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_valid", int'(bus.result_valid), 0);
    reset = 1'b0;
    tick();
    chk("mid_rst_no_pulse", pulse_cnt - p0, 0);
    $display("mid-window reset: ref=%0d busy=%0d", $signed(bus.ref_lvl), bus.busy);

    // en dropped mid-window, outputs held, retrain from a clean counter
    do_reset();
    bus.en        = 1'b1;
    bus.mode_4pam = 1'b1;
    tick();
    run_win(pat_off, NSYM);
    run_win(pat_off, NSYM);
    run_win(pat_off, 5);
    p0 = pulse_cnt;
    bus.en = 1'b0;
    tick();
    chk("en_lo_busy", int'(bus.busy), 0);
    chk("en_lo_ref_held", int'($signed(bus.ref_lvl)), 8192);
    chk("en_lo_err_held", int'($signed(bus.err_avg)), 1024);
    chk("en_lo_sq_held", int'(bus.err_sq_avg), 8);
    send(4096, sl);
    send(-4096, sl);
    chk("en_lo_no_pulse", pulse_cnt - p0, 0);
    bus.en        = 1'b1;
    bus.mode_4pam = 1'b0;
    tick();
    chk("en_hi_busy", int'(bus.busy), 1);
    run_win(pat_2p, NSYM);
    tick();
    chk("retrain_ref", int'($signed(bus.ref_lvl)), 4096);
    chk("retrain_err_held", int'($signed(bus.err_avg)), 1024);
    chk("retrain_no_pulse", pulse_cnt - p0, 0);
    run_win(pat_2p, NSYM);
    tick();
    chk("remeas_err_avg", int'($signed(bus.err_avg)), 0);
    chk("remeas_err_sq", int'(bus.err_sq_avg), 0);
    chk("remeas_pulse", pulse_cnt - p0, 1);
    $display("en toggle: ref=%0d err_avg=%0d pulses=%0d", $signed(bus.ref_lvl),
             $signed(bus.err_avg), pulse_cnt - p0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
